// File: rtl/rt_jtag_pkg.sv
// rt_jtag_pkg: TAP state encoding, instruction codes and the 1149.1 next-state function
package rt_jtag_pkg;
  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_BYPASS = '1;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PA_DR;
      PA_DR:  n = tms ? EX2_DR : PA_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PA_IR;
      PA_IR:  n = tms ? EX2_IR : PA_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/rt_jtag_sync_edge.sv
// rt_jtag_sync_edge: 2-flop synchronizer with optional single-cycle rise/fall strobes
// clk/rst: system clock, sync active-high reset; d: async pin; q: synchronized level; rise/fall: edge strobes (0 when EdgeEn=0)
module rt_jtag_sync_edge #(
  parameter bit   EdgeEn = 1'b0,
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? {2{RstVal}} : {sync_q[0], d};
  assign q = sync_q[1];
  if (EdgeEn) begin : g_edge
    logic prev_q;
    always_ff @(posedge clk) prev_q <= rst ? RstVal : q;
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
  end else begin : g_level
    assign rise = 1'b0;
    assign fall = 1'b0;
  end
endmodule

// File: rtl/rt_jtag_tap_os.sv
// rt_jtag_tap_os: oversampled JTAG TAP responder with IDCODE, BYPASS and a USER data register
// clk_i/rst_i: system clock, sync reset; jtag_*_i: async pins; jtag_td_o/jtag_tdo_oe_o: TDO and its enable;
// ir_o: current instruction; user_capture_o/_data_i: capture handshake; user_update_o/_data_o: update handshake
module rt_jtag_tap_os
  import rt_jtag_pkg::*;
#(
  parameter int                 IrWidth     = 5,
  parameter logic [31:0]        IdcodeValue = 32'h249511C3,
  parameter int                 UserDrWidth = 41,
  parameter logic [IrWidth-1:0] UserIr      = 5'h11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jtag_tck_i,
  input  logic                   jtag_tms_i,
  input  logic                   jtag_trst_ni,
  input  logic                   jtag_td_i,
  output logic                   jtag_td_o,
  output logic                   jtag_tdo_oe_o,
  output logic [IrWidth-1:0]     ir_o,
  output logic                   user_capture_o,
  input  logic [UserDrWidth-1:0] user_capture_data_i,
  output logic                   user_update_o,
  output logic [UserDrWidth-1:0] user_update_data_o
);
  localparam int DrWidth = UserDrWidth > 32 ? UserDrWidth : 32;
  localparam int IdxW = $clog2(DrWidth);
  localparam logic [IrWidth-1:0] IrIdcode = IrWidth'(IR_IDCODE);
  if (IdcodeValue[0] != 1'b1) begin : g_bad_idcode
    $error("IdcodeValue bit 0 must be 1");
  end
  logic tck_s, tck_rise, tck_fall, tms_s, tdi_s, trst_s;
  logic [6:0] unused_edges;
  rt_jtag_sync_edge #(.EdgeEn(1'b1), .RstVal(1'b0)) u_tck (
    .clk(clk_i), .rst(rst_i), .d(jtag_tck_i), .q(tck_s), .rise(tck_rise), .fall(tck_fall));
  rt_jtag_sync_edge #(.RstVal(1'b1)) u_tms (
    .clk(clk_i), .rst(rst_i), .d(jtag_tms_i), .q(tms_s), .rise(unused_edges[0]), .fall(unused_edges[1]));
  rt_jtag_sync_edge #(.RstVal(1'b0)) u_tdi (
    .clk(clk_i), .rst(rst_i), .d(jtag_td_i), .q(tdi_s), .rise(unused_edges[2]), .fall(unused_edges[3]));
  rt_jtag_sync_edge #(.RstVal(1'b1)) u_trst (
    .clk(clk_i), .rst(rst_i), .d(jtag_trst_ni), .q(trst_s), .rise(unused_edges[4]), .fall(unused_edges[5]));
  assign unused_edges[6] = tck_s;
  tap_state_e state_q, state_d;
  logic [IrWidth-1:0] ir_shift_q;
  logic [DrWidth-1:0] dr_q, dr_next;
  logic [IdxW-1:0] msb_idx;
  logic is_user, is_id;
  always_comb begin
    state_d = !trst_s ? TLR : tck_rise ? tap_next(state_q, tms_s) : state_q;
    is_user = ir_o == UserIr;
    is_id = ir_o == IrIdcode;
    // TDI enters at the top of whichever register is selected, not the top of the shared shifter
    msb_idx = is_user ? IdxW'(UserDrWidth - 1) : is_id ? IdxW'(31) : '0;
    dr_next = dr_q >> 1;
    dr_next[msb_idx] = tdi_s;
    user_capture_o = tck_rise && trst_s && state_q == CAP_DR && is_user;
  end
  always_ff @(posedge clk_i) state_q <= rst_i ? TLR : state_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_o <= IrIdcode;
      ir_shift_q <= '0;
      dr_q <= '0;
      jtag_td_o <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
      user_update_o <= 1'b0;
      user_update_data_o <= '0;
    end else if (!trst_s) begin
      ir_o <= IrIdcode;
      jtag_td_o <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
      user_update_o <= 1'b0;
    end else begin
      user_update_o <= 1'b0;
      if (tck_rise) begin
        if (state_d == TLR) ir_o <= IrIdcode;
        case (state_q)
          CAP_IR: ir_shift_q <= IrWidth'(1);
          SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IrWidth-1:1]};
          UPD_IR: ir_o <= ir_shift_q;
          CAP_DR: dr_q <= is_user ? DrWidth'(user_capture_data_i) : is_id ? DrWidth'(IdcodeValue) : '0;
          SH_DR:  dr_q <= dr_next;
          UPD_DR: if (is_user) begin
            user_update_data_o <= dr_q[UserDrWidth-1:0];
            user_update_o <= 1'b1;
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        jtag_tdo_oe_o <= state_q == SH_IR || state_q == SH_DR;
        jtag_td_o <= state_q == SH_IR ? ir_shift_q[0] : state_q == SH_DR ? dr_q[0] : jtag_td_o;
      end
    end
  end
endmodule
